bhg_raster_scanout: RTL and testbench

Raster timing generator and line-fetch initiator for the scrolling display path. It produces the sync signals and the horizontal/vertical active enables (`VID_xena`, `VID_yena`) consumed by the screen-scroll controller. It samples that controller's signed X/Y scroll offsets once per frame and issues one memory line-fetch request per active line, carrying the scrolled bitmap start address, to the DDR3 line-buffer reader.

---
 rtl/bhg_raster_pkg.sv | 49 ++++
 rtl/bhg_raster_counter.sv | 71 +++++++
 rtl/bhg_raster_scanout.sv | 189 ++++++++++++++++++
 tb/tb_bhg_raster_scanout.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bhg_raster_pkg.sv
// bhg_raster_pkg
// Shared types for the raster scan-out block:
//   raster_timing_t  - per-axis active/porch/sync lengths
//   TIMING_1080P     - default CEA 1080p timing
//   h_total/v_total  - derived line and frame lengths
//   req_state_t      - line-fetch request state machine encoding
//   clamp_offset     - maps a signed scroll offset to a non-negative one
package bhg_raster_pkg;

    typedef struct packed {
        logic [13:0] h_active;
        logic [13:0] h_fp;
        logic [13:0] h_sync;
        logic [13:0] h_bp;
        logic [13:0] v_active;
        logic [13:0] v_fp;
        logic [13:0] v_sync;
        logic [13:0] v_bp;
    } raster_timing_t;

    localparam raster_timing_t TIMING_1080P = '{
        h_active: 14'd1920, h_fp: 14'd88, h_sync: 14'd44, h_bp: 14'd148,
        v_active: 14'd1080, v_fp: 14'd4,  v_sync: 14'd5,  v_bp: 14'd36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        REQ  = 2'd2
    } req_state_t;

    function automatic logic [13:0] h_total(input raster_timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic logic [13:0] v_total(input raster_timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

    // Negative offsets would point before the bitmap origin; pin them to 0.
    function automatic logic [12:0] clamp_offset(input logic [13:0] v);
        if (v[13]) begin
            return 13'd0;
        end else begin
            return v[12:0];
        end
    endfunction

endpackage

// File: rtl/bhg_raster_counter.sv
// bhg_raster_counter
// Horizontal/vertical raster counters with sync and active-window decode.
// Ports:
//   CLK_IN, reset          - pixel clock, synchronous active-high reset
//   h_cnt, v_cnt           - current pixel / line position
//   hs, vs                 - active-high sync pulses
//   xena, yena             - horizontal / vertical active windows
// The decoded outputs are registered from the next counter values so they
// line up with the counter values shown on the same cycle.
module bhg_raster_counter
    import bhg_raster_pkg::*;
#(
    parameter raster_timing_t TIMING = TIMING_1080P
) (
    input  logic        CLK_IN,
    input  logic        reset,
    output logic [13:0] h_cnt,
    output logic [13:0] v_cnt,
    output logic        hs,
    output logic        vs,
    output logic        xena,
    output logic        yena
);

    localparam logic [13:0] HT       = h_total(TIMING);
    localparam logic [13:0] VT       = v_total(TIMING);
    localparam logic [13:0] HS_START = TIMING.h_active + TIMING.h_fp;
    localparam logic [13:0] HS_END   = HS_START + TIMING.h_sync;
    localparam logic [13:0] VS_START = TIMING.v_active + TIMING.v_fp;
    localparam logic [13:0] VS_END   = VS_START + TIMING.v_sync;

    logic [13:0] h_next_s;
    logic [13:0] v_next_s;

    // Next counter position: h wraps at end of line, v advances on that wrap.
    always_comb begin
        h_next_s = h_cnt + 14'd1;
        v_next_s = v_cnt;
        if (h_cnt == HT - 14'd1) begin
            h_next_s = 14'd0;
            if (v_cnt == VT - 14'd1) begin
                v_next_s = 14'd0;
            end else begin
                v_next_s = v_cnt + 14'd1;
            end
        end else begin
            h_next_s = h_cnt + 14'd1;
            v_next_s = v_cnt;
        end
    end

    // Counter registers and their decoded sync/enable flags.
    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            h_cnt <= 14'd0;
            v_cnt <= 14'd0;
            hs    <= 1'b0;
            vs    <= 1'b0;
            xena  <= 1'b1;
            yena  <= 1'b1;
        end else begin
            h_cnt <= h_next_s;
            v_cnt <= v_next_s;
            hs    <= (h_next_s >= HS_START) && (h_next_s < HS_END);
            vs    <= (v_next_s >= VS_START) && (v_next_s < VS_END);
            xena  <= (h_next_s < TIMING.h_active);
            yena  <= (v_next_s < TIMING.v_active);
        end
    end

endmodule

// File: rtl/bhg_raster_scanout.sv
// bhg_raster_scanout
// Raster timing generator plus per-line memory fetch initiator.
// Ports:
//   CLK_IN, reset                 - pixel clock, synchronous active-high reset
//   scroll_x, scroll_y            - signed bitmap offsets (latched once per frame)
//   bitmap_width                  - bitmap row pitch in pixels (latched per frame)
//   hs, vs, VID_xena, VID_yena    - sync and active windows
//   h_cnt, v_cnt                  - raster position
//   line_req, line_addr, line_num - level fetch request with its address/line
//   line_ack                      - fetch accepted (only honoured while requesting)
//   line_miss                     - pulse when an unacked request is abandoned
// Each line's fetch is triggered at the end of the preceding line's active
// region; the address takes two cycles (multiply, then add) before the
// request is presented.
module bhg_raster_scanout
    import bhg_raster_pkg::*;
#(
    parameter logic [13:0] H_ACTIVE  = TIMING_1080P.h_active,
    parameter logic [13:0] H_FP      = TIMING_1080P.h_fp,
    parameter logic [13:0] H_SYNC    = TIMING_1080P.h_sync,
    parameter logic [13:0] H_BP      = TIMING_1080P.h_bp,
    parameter logic [13:0] V_ACTIVE  = TIMING_1080P.v_active,
    parameter logic [13:0] V_FP      = TIMING_1080P.v_fp,
    parameter logic [13:0] V_SYNC    = TIMING_1080P.v_sync,
    parameter logic [13:0] V_BP      = TIMING_1080P.v_bp,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic               CLK_IN,
    input  logic               reset,
    input  logic signed [13:0] scroll_x,
    input  logic signed [13:0] scroll_y,
    input  logic        [15:0] bitmap_width,
    output logic               hs,
    output logic               vs,
    output logic               VID_xena,
    output logic               VID_yena,
    output logic        [13:0] h_cnt,
    output logic        [13:0] v_cnt,
    output logic               line_req,
    output logic        [31:0] line_addr,
    output logic        [13:0] line_num,
    input  logic               line_ack,
    output logic               line_miss
);

    localparam raster_timing_t TIMING = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    };
    localparam logic [13:0] VT = v_total(TIMING);

    bhg_raster_counter #(.TIMING(TIMING)) u_counter (
        .CLK_IN (CLK_IN),
        .reset  (reset),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .hs     (hs),
        .vs     (vs),
        .xena   (VID_xena),
        .yena   (VID_yena)
    );

    logic [12:0] sx_r;
    logic [12:0] sy_r;
    logic [15:0] pitch_r;
    req_state_t  state_r;
    req_state_t  state_next_s;
    logic        calc_step_r;
    logic        calc_step_next_s;
    logic        miss_next_s;
    logic [13:0] pend_line_r;
    logic [31:0] prod_r;
    logic        trig_s;
    logic [13:0] trig_line_s;
    logic        latch_s;
    logic [15:0] row_s;
    logic [31:0] sum_s;

    // Frame latch point is the first pixel of the last blanking line, just
    // before line 0's trigger on that same line.
    assign latch_s = (h_cnt == 14'd0) && (v_cnt == VT - 14'd1);
    assign row_s   = {3'd0, sy_r} + {2'd0, pend_line_r};
    assign sum_s   = BASE_ADDR + prod_r + {19'd0, sx_r};

    // Trigger decode: line n is requested at h=H_ACTIVE of line n-1
    // (line 0 from the last line of the frame); no trigger past the last
    // active line.
    always_comb begin
        trig_s      = 1'b0;
        trig_line_s = 14'd0;
        if (h_cnt == H_ACTIVE) begin
            if (v_cnt == VT - 14'd1) begin
                trig_s      = 1'b1;
                trig_line_s = 14'd0;
            end else if (v_cnt < V_ACTIVE - 14'd1) begin
                trig_s      = 1'b1;
                trig_line_s = v_cnt + 14'd1;
            end else begin
                trig_s      = 1'b0;
                trig_line_s = 14'd0;
            end
        end else begin
            trig_s      = 1'b0;
            trig_line_s = 14'd0;
        end
    end

    // Request state machine next-state; a trigger always wins and restarts CALC.
    always_comb begin
        state_next_s     = state_r;
        calc_step_next_s = calc_step_r;
        miss_next_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (trig_s) begin
                    state_next_s     = CALC;
                    calc_step_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (trig_s) begin
                    miss_next_s      = 1'b1;
                    state_next_s     = CALC;
                    calc_step_next_s = 1'b0;
                end else if (calc_step_r) begin
                    state_next_s = REQ;
                end else begin
                    calc_step_next_s = 1'b1;
                end
            end
            REQ: begin
                if (trig_s) begin
                    // An ack arriving on the trigger cycle still completes the old line.
                    miss_next_s      = ~line_ack;
                    state_next_s     = CALC;
                    calc_step_next_s = 1'b0;
                end else if (line_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REQ;
                end
            end
            default: begin
                state_next_s     = IDLE;
                calc_step_next_s = 1'b0;
            end
        endcase
    end

    // State, frame registers, address pipeline and registered request outputs.
    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            state_r     <= IDLE;
            calc_step_r <= 1'b0;
            sx_r        <= 13'd0;
            sy_r        <= 13'd0;
            pitch_r     <= 16'd0;
            pend_line_r <= 14'd0;
            prod_r      <= 32'd0;
            line_req    <= 1'b0;
            line_addr   <= 32'd0;
            line_num    <= 14'd0;
            line_miss   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            calc_step_r <= calc_step_next_s;
            line_req    <= (state_next_s == REQ);
            line_miss   <= miss_next_s;
            if (latch_s) begin
                sx_r    <= clamp_offset(scroll_x);
                sy_r    <= clamp_offset(scroll_y);
                pitch_r <= bitmap_width;
            end
            if (trig_s) begin
                pend_line_r <= trig_line_s;
            end
            if ((state_r == CALC) && !calc_step_r) begin
                prod_r <= {16'd0, row_s} * {16'd0, pitch_r};
            end
            if ((state_r == CALC) && calc_step_r && !trig_s) begin
                line_addr <= sum_s;
                line_num  <= pend_line_r;
            end
        end
    end

endmodule

// File: tb/tb_bhg_raster_scanout.sv
// tb_bhg_raster_scanout
// Bench for bhg_raster_scanout on a reduced raster (H 8/2/2/2, V 4/1/1/1,
// BASE_ADDR 100). A reference model derived from absolute cycle position
// predicts every output each cycle; directed tables and sequences cover the
// address arithmetic, scroll latching, misses, reset and delayed acks.
module tb_bhg_raster_scanout;

    localparam int HA = 8;
    localparam int HT = 8 + 2 + 2 + 2;
    localparam int VA = 4;
    localparam int VT = 4 + 1 + 1 + 1;
    localparam logic [31:0] BASE = 32'd100;

    logic               CLK_IN;
    logic               reset;
    logic signed [13:0] scroll_x;
    logic signed [13:0] scroll_y;
    logic        [15:0] bitmap_width;
    logic               hs, vs, VID_xena, VID_yena;
    logic        [13:0] h_cnt, v_cnt;
    logic               line_req;
    logic        [31:0] line_addr;
    logic        [13:0] line_num;
    logic               line_ack;
    logic               line_miss;

    int checks = 0;
    int errors = 0;

    bhg_raster_scanout #(
        .H_ACTIVE(14'd8), .H_FP(14'd2), .H_SYNC(14'd2), .H_BP(14'd2),
        .V_ACTIVE(14'd4), .V_FP(14'd1), .V_SYNC(14'd1), .V_BP(14'd1),
        .BASE_ADDR(32'd100)
    ) dut (
        .CLK_IN       (CLK_IN),
        .reset        (reset),
        .scroll_x     (scroll_x),
        .scroll_y     (scroll_y),
        .bitmap_width (bitmap_width),
        .hs           (hs),
        .vs           (vs),
        .VID_xena     (VID_xena),
        .VID_yena     (VID_yena),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .line_req     (line_req),
        .line_addr    (line_addr),
        .line_num     (line_num),
        .line_ack     (line_ack),
        .line_miss    (line_miss)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge and hold through the next rising edge.
    task automatic cyc();
        @(negedge CLK_IN);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_rise(input string name, output logic [31:0] addr, output logic [13:0] num);
        logic prev;
        bit   seen;
        prev = line_req;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cyc();
            if (line_req && !prev) seen = 1'b1;
            prev = line_req;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: line_req rise seen=0, expected 1 within 300 cycles", name);
        end
        addr = line_addr;
        num  = line_num;
    endtask

    // Reference model: positions come from the cycle count since reset; a
    // request is outstanding from its trigger until acked or superseded and
    // becomes visible 3 cycles after the trigger.
    initial begin : model
        bit          m_valid;
        int          m_cyc, m_trig, h, v, n;
        bit          m_pend, m_req, m_miss, new_req;
        logic [12:0] m_sx, m_sy;
        logic [15:0] m_pitch, row;
        logic [31:0] m_addr, m_pa;
        logic [13:0] m_num, m_pn;
        logic [79:0] exp_v, act_v;
        m_valid = 1'b0;
        m_cyc = 0; m_trig = 0; m_pend = 0; m_req = 0; m_miss = 0;
        m_sx = '0; m_sy = '0; m_pitch = '0; m_addr = '0; m_num = '0; m_pa = '0; m_pn = '0;
        forever begin
            @(negedge CLK_IN);
            if (reset === 1'b1) begin
                m_valid = 1'b1;
                m_cyc = 0; m_pend = 0; m_req = 0; m_miss = 0;
                m_sx = '0; m_sy = '0; m_pitch = '0; m_addr = '0; m_num = '0;
            end else if (m_valid) begin
                h = m_cyc % HT;
                v = (m_cyc / HT) % VT;
                m_miss = 1'b0;
                if (m_req && line_ack) m_pend = 1'b0;
                if (h == HA && (v == VT - 1 || v < VA - 1)) begin
                    n = (v == VT - 1) ? 0 : v + 1;
                    if (m_pend) m_miss = 1'b1;
                    m_pend = 1'b1;
                    m_trig = m_cyc;
                    m_pn   = 14'(n);
                    row    = 16'(32'(m_sy) + 32'(n));
                    m_pa   = BASE + 32'(row) * 32'(m_pitch) + 32'(m_sx);
                end
                if (h == 0 && v == VT - 1) begin
                    m_sx    = (scroll_x < 0) ? 13'd0 : scroll_x[12:0];
                    m_sy    = (scroll_y < 0) ? 13'd0 : scroll_y[12:0];
                    m_pitch = bitmap_width;
                end
                m_cyc++;
                new_req = m_pend && (m_cyc - m_trig >= 3);
                if (new_req && !m_req) begin
                    m_addr = m_pa;
                    m_num  = m_pn;
                end
                m_req = new_req;
            end
            if (m_valid) begin
                h = m_cyc % HT;
                v = (m_cyc / HT) % VT;
                exp_v = {14'(h), 14'(v), (h >= 10 && h < 12), (v >= 5 && v < 6),
                         (h < HA), (v < VA), m_req, m_miss, m_num, m_addr};
                act_v = {h_cnt, v_cnt, hs, vs, VID_xena, VID_yena,
                         line_req, line_miss, line_num, line_addr};
                chk("model", act_v, exp_v);
            end
        end
    end

    typedef struct {
        logic [13:0] sx;
        logic [13:0] sy;
        logic [15:0] w;
        logic [31:0] a0, a1, a2, a3;
    } addr_vec_t;

    initial begin : stim
        addr_vec_t   tbl[5];
        logic [31:0] a;
        logic [13:0] nm;
        logic [55:0] seq;
        int          rises, misses, hs_n, vs_n, xe_n, ye_n;
        logic        prev;

        tbl[0] = '{14'd3,     14'd2,     16'd20,    32'd143, 32'd163, 32'd183, 32'd203};
        tbl[1] = '{-14'sd5,   -14'sd1,   16'd20,    32'd100, 32'd120, 32'd140, 32'd160};
        tbl[2] = '{14'd10,    14'd0,     16'd0,     32'd110, 32'd110, 32'd110, 32'd110};
        tbl[3] = '{-14'sd1,   14'd7,     16'd300,   32'd2200, 32'd2500, 32'd2800, 32'd3100};
        tbl[4] = '{14'd8191,  14'd8191,  16'd65535, 32'd536805476, 32'd536871011,
                   32'd536936546, 32'd537002081};

        reset = 1'b1; line_ack = 1'b1;
        scroll_x = '0; scroll_y = '0; bitmap_width = '0;
        do_reset();

        // Reset values, observed right after the reset edges.
        chk("reset_state", 80'({h_cnt, v_cnt, hs, vs, VID_xena, VID_yena, line_req, line_miss, line_num, line_addr}),
            80'({14'd0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0, 32'd0}));

        // One full frame starting at line 0's request: 4 requests, lines 0..3.
        nm = 14'd1;
        for (int k = 0; k < 4 && nm != 14'd0; k++) wait_rise("first_line0", a, nm);
        rises = 1; seq = {42'd0, line_num};
        hs_n = int'(hs); vs_n = int'(vs); xe_n = int'(VID_xena); ye_n = int'(VID_yena);
        prev = line_req;
        for (int i = 0; i < HT * VT - 1; i++) begin
            cyc();
            if (line_req && !prev) begin
                rises++;
                seq = {seq[41:0], line_num};
            end
            prev = line_req;
            hs_n += int'(hs); vs_n += int'(vs); xe_n += int'(VID_xena); ye_n += int'(VID_yena);
        end
        chk("req_per_frame", 80'(rises), 80'(4));
        chk("line_num_seq", 80'(seq), 80'({14'd0, 14'd1, 14'd2, 14'd3}));
        chk("hs_cycles", 80'(hs_n), 80'(14));
        chk("vs_cycles", 80'(vs_n), 80'(14));
        chk("xena_cycles", 80'(xe_n), 80'(56));
        chk("yena_cycles", 80'(ye_n), 80'(56));

        // Address table: the first frame runs at 0/0/0, the second uses the row.
        for (int r = 0; r < 5; r++) begin
            line_ack = 1'b1;
            scroll_x = tbl[r].sx; scroll_y = tbl[r].sy; bitmap_width = tbl[r].w;
            do_reset();
            nm = 14'd1;
            for (int k = 0; k < 4 && nm != 14'd0; k++) wait_rise("tbl_line0", a, nm);
            chk($sformatf("tbl%0d_l0", r), 80'(a), 80'(tbl[r].a0));
            wait_rise("tbl_l1", a, nm); chk($sformatf("tbl%0d_l1", r), 80'(a), 80'(tbl[r].a1));
            wait_rise("tbl_l2", a, nm); chk($sformatf("tbl%0d_l2", r), 80'(a), 80'(tbl[r].a2));
            wait_rise("tbl_l3", a, nm); chk($sformatf("tbl%0d_l3", r), 80'(a), 80'(tbl[r].a3));
        end

        // Mid-frame scroll change applies only from the next frame.
        scroll_x = 14'd3; scroll_y = 14'd2; bitmap_width = 16'd20;
        do_reset();
        nm = 14'd1;
        for (int k = 0; k < 4 && nm != 14'd0; k++) wait_rise("mid_line0", a, nm);
        wait_rise("mid_l1", a, nm);
        scroll_x = 14'd9; scroll_y = 14'd9; bitmap_width = 16'd50;
        wait_rise("mid_l2", a, nm); chk("mid_l2_addr", 80'(a), 80'(183));
        wait_rise("mid_l3", a, nm); chk("mid_l3_addr", 80'(a), 80'(203));
        wait_rise("mid_next", a, nm); chk("mid_next_l0", 80'({nm, a}), 80'({14'd0, 32'd559}));

        // No acks for two frames: every trigger after the first abandons a request.
        line_ack = 1'b0;
        do_reset();
        misses = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            cyc();
            misses += int'(line_miss);
        end
        chk("noack_misses", 80'(misses), 80'(7));
        chk("noack_req_high", 80'({line_req, line_num}), 80'({1'b1, 14'd0}));

        // Reset while requesting clears the request and the counters at once.
        reset = 1'b1;
        cyc();
        chk("reset_in_req", 80'({line_req, h_cnt, v_cnt}), 80'({1'b0, 14'd0, 14'd0}));
        cyc();
        reset = 1'b0;

        // Ack held back 5 cycles after the request: one request, no miss.
        line_ack = 1'b0;
        do_reset();
        wait_rise("delayed_ack", a, nm);
        rises = 1; misses = 0; prev = line_req;
        for (int i = 0; i < 12; i++) begin
            line_ack = (i == 4);
            cyc();
            if (line_req && !prev) rises++;
            prev = line_req;
            misses += int'(line_miss);
        end
        line_ack = 1'b0;
        chk("delayed_ack_reqs", 80'(rises), 80'(1));
        chk("delayed_ack_miss", 80'(misses), 80'(0));
        chk("delayed_ack_done", 80'({line_req, line_num}), 80'({1'b0, 14'd1}));

        // Randomized traffic checked cycle by cycle by the model.
        for (int i = 0; i < 800; i++) begin
            line_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) begin
                scroll_x     = 14'($urandom);
                scroll_y     = 14'($urandom);
                bitmap_width = 16'($urandom);
            end
            reset = (i == 400);
            cyc();
        end
        reset = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
